// File: rtl/stack_ctrl.sv
// Stack-operation sequencer: SP read, one data-memory access, then SP/GPR/PC write-back.
// Downward-growing stack, pre-decrement push and post-increment pop.
module stack_ctrl #(
  parameter logic [31:0] STACK_TOP   = 32'h0000_0400,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] push_data,
  input  logic [31:0] ret_addr,
  input  logic [4:0]  dr_in,
  input  logic [31:0] sp_in,
  output logic        readSP,
  output logic        writeSP,
  output logic [31:0] write_dataSP,
  output logic        writeReg,
  output logic [4:0]  dr,
  output logic [31:0] write_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        pc_load,
  output logic [31:0] pc_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] OP_POP = 2'b01;
  localparam logic [1:0] OP_RET = 2'b11;

  typedef enum logic [2:0] {IDLE, RDSP, MEM, WB, ERR} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [31:0] data_q;
  logic [31:0] sp_q;
  logic [31:0] rdata_q;
  logic [4:0]  dr_q;
  logic        pop_type;

  // POP and RET both have op[0] set; they read at SP and post-increment.
  assign pop_type = op_q[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      op_q    <= 2'b00;
      data_q  <= 32'h0;
      sp_q    <= 32'h0;
      rdata_q <= 32'h0;
      dr_q    <= 5'h0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          op_q   <= op;
          data_q <= op[1] ? ret_addr : push_data;
          dr_q   <= dr_in;
        end
        RDSP: sp_q <= sp_in;
        MEM:  if (mem_ack) rdata_q <= mem_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    readSP       = 1'b0;
    writeSP      = 1'b0;
    write_dataSP = 32'h0;
    writeReg     = 1'b0;
    dr           = 5'h0;
    write_data   = 32'h0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 32'h0;
    mem_wdata    = 32'h0;
    pc_load      = 1'b0;
    pc_out       = 32'h0;
    busy         = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RDSP;
      end
      RDSP: begin
        readSP = 1'b1;
        if (pop_type ? (sp_in == STACK_TOP) : (sp_in == STACK_LIMIT))
          state_nxt = ERR;
        else
          state_nxt = MEM;
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_we    = ~pop_type;
        mem_addr  = pop_type ? sp_q : sp_q - 32'd1;
        mem_wdata = pop_type ? 32'h0 : data_q;
        if (mem_ack) state_nxt = WB;
      end
      WB: begin
        writeSP      = 1'b1;
        write_dataSP = pop_type ? sp_q + 32'd1 : sp_q - 32'd1;
        if (op_q == OP_POP) begin
          writeReg   = 1'b1;
          dr         = dr_q;
          write_data = rdata_q;
        end
        if (op_q == OP_RET) begin
          pc_load = 1'b1;
          pc_out  = rdata_q;
        end
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        done      = 1'b1;
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Multi-cycle stack-operation sequencer sitting between the instruction decoder and the register bank / data memory. Executes PUSH, POP, CALL and RET by reading the stack pointer through the register bank's SP read path, performing one data-memory access, then writing back the updated SP (and the popped value or return PC). It initiates every SP read/write the register bank services. The stack grows downward with pre-decrement push and post-increment pop.

## Interface
- STACK_TOP, 32'h0000_0400: SP value of an empty stack; POP/RET at this SP is underflow.
- STACK_LIMIT, 32'h0000_0000: lowest legal stack word; PUSH/CALL with SP == STACK_LIMIT is overflow.
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-low; sampled on posedge clk.
- start  in  1  operation request; accepted only in IDLE.
- op  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET.
- push_data  in  32  value to push (PUSH).
- ret_addr  in  32  return address to push (CALL).
- dr_in  in  5  destination register for POP.
- sp_in  in  32  SP value returned by the register bank while readSP is high.
- readSP  out  1  requests SP on the register bank read port.
- writeSP  out  1  SP write strobe.
- write_dataSP  out  32  new SP value.
- writeReg  out  1  GPR write strobe (POP only).
- dr  out  5  GPR destination index.
- write_data  out  32  popped value for GPR.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  word address.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  load data, valid with mem_ack.
- mem_ack  in  1  memory completion, 1 cycle.
- pc_load  out  1  PC load strobe (RET only).
- pc_out  out  32  popped return address.
- busy  out  1  high in every state except IDLE.
- done  out  1  1-cycle completion pulse.
- err  out  1  1-cycle pulse with done on overflow/underflow.

## Operation
- States: IDLE, RDSP, MEM, WB, ERR.
- IDLE: start=1 latches op, push_data/ret_addr, dr_in; -> RDSP. start while busy is ignored (not queued).
- RDSP: readSP=1; sp_in latched at end of cycle. PUSH/CALL with sp_in == STACK_LIMIT, or POP/RET with sp_in == STACK_TOP -> ERR; else -> MEM.
- MEM: mem_req=1. PUSH/CALL: mem_we=1, mem_addr=SP-1, mem_wdata=push_data/ret_addr. POP/RET: mem_we=0, mem_addr=SP. mem_addr/mem_wdata/mem_we stable until ack. mem_ack=1 -> latch mem_rdata, -> WB.
- WB: writeSP=1, write_dataSP = SP-1 (PUSH/CALL) or SP+1 (POP/RET), 32-bit modulo. POP: writeReg=1, dr=latched dr_in, write_data=loaded word. RET: pc_load=1, pc_out=loaded word. done=1. -> IDLE.
- ERR: done=1, err=1; no memory access, no SP/GPR/PC write. -> IDLE.
- mem_ack outside MEM ignored.
- All strobes (readSP, writeSP, writeReg, pc_load, mem_req, done, err) are 0 in states not listed for them.

## Timing
- Reset (reset=0 at posedge): state IDLE; all strobes 0; write_dataSP, write_data, pc_out, mem_addr, mem_wdata, dr = 0. Applies mid-operation: pending access abandoned, no SP write; late mem_ack afterwards ignored.
- start sampled at edge N: RDSP in cycle N+1, MEM from N+2. With mem_ack in first MEM cycle, WB/done in N+3; each extra wait cycle adds 1.
- Error path: done/err in cycle N+2.
- New start accepted in the cycle after done (IDLE), giving 4-cycle back-to-back throughput with zero-wait memory.
- Regbank writes occur on the posedge ending WB; SP read in the next RDSP reflects it.

## Test plan
- Reset, SP=32'h400, PUSH push_data=32'hDEAD_BEEF, ack same cycle -> mem write addr 32'h3FF data 32'hDEAD_BEEF, writeSP with 32'h3FF, done 3 cycles after start.
- Then POP dr_in=5 with 2 wait cycles, mem_rdata=32'hDEAD_BEEF -> read addr 32'h3FF held 3 cycles, writeReg dr=5 data 32'hDEAD_BEEF, writeSP 32'h400, done at cycle 5.
- CALL ret_addr=32'h40 then RET -> write 32'h40 at 32'h3FF; RET gives pc_load=1, pc_out=32'h40, SP back to 32'h400, writeReg never high.
- POP with sp_in=STACK_TOP=32'h400 -> no mem_req, no writeSP, done=err=1 at cycle 2; PUSH with sp_in=STACK_LIMIT=0 -> same.
- reset=0 during MEM wait of a PUSH, mem_ack one cycle later -> mem_req drops, no writeSP, busy=0, done never pulses.
- start pulsed while busy -> ignored; only the first operation completes, one done pulse.
